// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 32x32 register file: merges in-order WB results with
// MDU results, queueing the latter in a small FIFO and flagging pending destinations.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbValid,
  input  logic [4:0]  wbDest,
  input  logic [31:0] wbData,
  input  logic        mduValid,
  output logic        mduReady,
  input  logic [4:0]  mduDest,
  input  logic [31:0] mduData,
  input  logic [4:0]  queryReg,
  output logic        pendingHit,
  output logic        stallReq,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [4:0]        r_dest [DEPTH];
  logic [31:0]       r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [WAIT_W-1:0] r_wait;
  logic              r_stall, r_reg_write;
  logic [4:0]        r_write_reg;
  logic [31:0]       r_write_data;

  logic w_wb_act, w_mdu_hs, w_fifo_empty, w_pop, w_bypass, w_push, w_fifo_hit;

  assign mduReady     = (r_count < CNT_FULL);
  assign w_wb_act     = wbValid && (wbDest != 5'd0);
  assign w_mdu_hs     = mduValid && mduReady;
  assign w_fifo_empty = (r_count == '0);
  assign w_pop        = !w_wb_act && !w_fifo_empty;
  assign w_bypass     = !w_wb_act && w_fifo_empty && w_mdu_hs && (mduDest != 5'd0);
  // A zero-destination MDU result completes its handshake but is simply dropped.
  assign w_push       = w_mdu_hs && (mduDest != 5'd0) && !w_bypass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= 32'd0;
    end else if (w_wb_act) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= wbDest;
      r_write_data <= wbData;
    end else if (w_pop) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= r_dest[r_rd_ptr];
      r_write_data <= r_data[r_rd_ptr];
    end else if (w_bypass) begin
      r_reg_write  <= 1'b1;
      r_write_reg  <= mduDest;
      r_write_data <= mduData;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wr_ptr] <= mduDest;
      r_data[r_wr_ptr] <= mduData;
    end
  end

  // stallReq follows the counter one edge late, so it drops the edge after a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_stall <= (r_wait == WAIT_SAT);
      if (w_fifo_empty || w_pop)
        r_wait <= '0;
      else if (w_wb_act && (r_wait != WAIT_SAT))
        r_wait <= r_wait + WAIT_W'(1);
    end
  end

  always_comb begin
    w_fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (r_vld[i] && (r_dest[i] == queryReg)) w_fifo_hit = 1'b1;
  end

  assign pendingHit    = (queryReg != 5'd0) &&
                         (w_fifo_hit || (r_reg_write && (r_write_reg == queryReg)));
  assign stallReq      = r_stall;
  assign regWrite      = r_reg_write;
  assign writeRegister = r_write_reg;
  assign writeData     = r_write_data;

endmodule
